// File: rtl/spi_cmd_sched.sv
// SPI command scheduler: buffers flash requests in a FIFO and issues them one at a
// time to the spi_flash controller, optionally preceded by a write-enable (0x06), and
// holds off after program/erase commands for a fixed busy time.
// Optional feature macro: SPI_CMD_SCHED_AUTO_WREN_EN (inserts WREN before program/erase).
module spi_cmd_sched #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [15:0] WAIT_PP = 16'd800,
  parameter logic [15:0] WAIT_ER = 16'd4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [39:0] req_in,
  input  logic        req_vld,
  output logic        req_rdy,
  output logic [39:0] cmd_in,
  output logic        cmd_vld,
  input  logic        cmd_rdy,
  output logic        busy
);

  localparam int unsigned    PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned    CntW    = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [39:0]    WrenCmd = {8'h06, 24'h0, 8'h0};

`ifdef SPI_CMD_SCHED_AUTO_WREN_EN
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWren = 2'd1,
    StCmd  = 2'd2,
    StWait = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCmd  = 2'd2,
    StWait = 2'd3
  } state_e;
`endif

  state_e state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic        cmd_vld_q, cmd_vld_d;
  logic [39:0] cmd_in_q, cmd_in_d;

  // Request FIFO
  logic [39:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full, empty, push, pop;
  logic [39:0]     head;
  logic            head_pp, head_er;

  assign full    = (count_q == DepthC);
  assign empty   = (count_q == '0);
  assign req_rdy = ~full;
  assign push    = req_vld & ~full;
  // cmd_vld is always high in StCmd, so the handshake reduces to cmd_rdy there
  assign pop     = (state_q == StCmd) & cmd_rdy;
  assign head    = mem_q[rd_ptr_q];

  assign cmd_in  = cmd_in_q;
  assign cmd_vld = cmd_vld_q;
  assign busy    = ~empty | (state_q != StIdle);

  // Opcode classification of the FIFO head
  always_comb begin
    head_pp = 1'b0;
    head_er = 1'b0;
    case (head[39:32])
      8'h02, 8'h38:                      head_pp = 1'b1;
      8'h20, 8'h52, 8'hD8, 8'h60, 8'hC7: head_er = 1'b1;
      default: ;
    endcase
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= req_in;
  end

  // State register, wait counter and registered command outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      cmd_vld_q <= 1'b0;
      cmd_in_q  <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cmd_vld_q <= cmd_vld_d;
      cmd_in_q  <= cmd_in_d;
    end
  end

  // Next-state logic and wait counter load/decrement
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      StIdle: begin
        if (!empty) begin
`ifdef SPI_CMD_SCHED_AUTO_WREN_EN
          state_d = (head_pp | head_er) ? StWren : StCmd;
`else
          state_d = StCmd;
`endif
        end
      end
`ifdef SPI_CMD_SCHED_AUTO_WREN_EN
      StWren: begin
        if (cmd_rdy) state_d = StCmd;
      end
`endif
      StCmd: begin
        if (pop) begin
          if (head_pp && (WAIT_PP != 16'd0)) begin
            state_d = StWait;
            wait_d  = WAIT_PP;
          end else if (head_er && (WAIT_ER != 16'd0)) begin
            state_d = StWait;
            wait_d  = WAIT_ER;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StWait: begin
        // The loaded value counts the cycles spent in this state, including the last one
        if (wait_q <= 16'd1) begin
          state_d = StIdle;
          wait_d  = '0;
        end else begin
          wait_d = wait_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so cmd_vld/cmd_in come straight from flops
  always_comb begin
    cmd_vld_d = 1'b0;
    cmd_in_d  = '0;
    case (state_d)
`ifdef SPI_CMD_SCHED_AUTO_WREN_EN
      StWren: begin
        cmd_vld_d = 1'b1;
        cmd_in_d  = WrenCmd;
      end
`endif
      StCmd: begin
        cmd_vld_d = 1'b1;
        cmd_in_d  = head;
      end
      default: ;
    endcase
  end

endmodule
